// File: rtl/prf_wb_queue_if.sv
// Bundle of functional-unit completion inputs and PRF write-port outputs
// for the writeback queue.
interface prf_wb_queue_if #(
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 7,
  parameter int DATA_W = 64
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              alu_sim_done;
  logic [IDX_W-1:0]  alu_sim_pr_idx;
  logic [DATA_W-1:0] alu_sim_pr_value;
  logic              alu_mul_done;
  logic [IDX_W-1:0]  alu_mul_pr_idx;
  logic [DATA_W-1:0] alu_mul_pr_value;
  logic              alu_mem_done;
  logic [IDX_W-1:0]  alu_mem_pr_idx;
  logic [DATA_W-1:0] alu_mem_pr_value;

  logic              wbq_ready;
  logic              prf_wr_enable0;
  logic [IDX_W-1:0]  prf_pr_idx0;
  logic [DATA_W-1:0] prf_pr_value0;
  logic              prf_wr_enable1;
  logic [IDX_W-1:0]  prf_pr_idx1;
  logic [DATA_W-1:0] prf_pr_value1;
  logic [CNT_W-1:0]  wbq_count;
  logic              wbq_overflow;

  modport slave (
    input  alu_sim_done, alu_sim_pr_idx, alu_sim_pr_value,
    input  alu_mul_done, alu_mul_pr_idx, alu_mul_pr_value,
    input  alu_mem_done, alu_mem_pr_idx, alu_mem_pr_value,
    output wbq_ready,
    output prf_wr_enable0, prf_pr_idx0, prf_pr_value0,
    output prf_wr_enable1, prf_pr_idx1, prf_pr_value1,
    output wbq_count, wbq_overflow
  );

  modport master (
    output alu_sim_done, alu_sim_pr_idx, alu_sim_pr_value,
    output alu_mul_done, alu_mul_pr_idx, alu_mul_pr_value,
    output alu_mem_done, alu_mem_pr_idx, alu_mem_pr_value,
    input  wbq_ready,
    input  prf_wr_enable0, prf_pr_idx0, prf_pr_value0,
    input  prf_wr_enable1, prf_pr_idx1, prf_pr_value1,
    input  wbq_count, wbq_overflow
  );
endinterface

// File: rtl/prf_wb_queue.sv
// Writeback queue: accepts up to three FU results per cycle and drains up to
// two per cycle onto the PRF write ports, oldest first.
module prf_wb_queue #(
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 7,
  parameter int DATA_W = 64
) (
  input  logic           clock,
  input  logic           reset,
  prf_wb_queue_if.slave  wbq
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [DATA_W-1:0] data_t;

  idx_t               idx_mem_q [DEPTH];
  idx_t               idx_mem_d [DEPTH];
  data_t              val_mem_q [DEPTH];
  data_t              val_mem_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  logic               ready;
  logic               en0, en1;
  logic [PTR_W-1:0]   head_p1;
  logic [PTR_W-1:0]   wr_ptr;
  logic [1:0]         push;
  logic [1:0]         pop;
  logic [2:0]         done_vec;
  idx_t               in_idx [3];
  data_t              in_val [3];

  // Readiness and drain enables depend only on registered occupancy.
  assign ready   = (count_q <= CNT_W'(DEPTH - 3));
  assign en0     = (count_q != '0);
  assign en1     = (count_q >= CNT_W'(2));
  assign head_p1 = head_q + PTR_W'(1);

  always_comb begin
    done_vec  = {wbq.alu_mem_done, wbq.alu_mul_done, wbq.alu_sim_done};
    in_idx[0] = wbq.alu_sim_pr_idx;
    in_idx[1] = wbq.alu_mul_pr_idx;
    in_idx[2] = wbq.alu_mem_pr_idx;
    in_val[0] = wbq.alu_sim_pr_value;
    in_val[1] = wbq.alu_mul_pr_value;
    in_val[2] = wbq.alu_mem_pr_value;
  end

  // Accepted results are packed at tail, tail+1, tail+2 in sim/mul/mem order.
  always_comb begin
    idx_mem_d = idx_mem_q;
    val_mem_d = val_mem_q;
    ovf_d     = ovf_q;
    push      = '0;
    wr_ptr    = tail_q;
    for (int unsigned u = 0; u < 3; u++) begin
      if (done_vec[u]) begin
        if (ready) begin
          idx_mem_d[wr_ptr] = in_idx[u];
          val_mem_d[wr_ptr] = in_val[u];
          wr_ptr            = wr_ptr + PTR_W'(1);
          push              = push + 2'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
    pop     = {1'b0, en0} + {1'b0, en1};
    tail_d  = tail_q + PTR_W'(push);
    head_d  = head_q + PTR_W'(pop);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only observed while counted as valid.
  always_ff @(posedge clock) begin
    idx_mem_q <= idx_mem_d;
    val_mem_q <= val_mem_d;
  end

  assign wbq.wbq_ready      = ready;
  assign wbq.wbq_count      = count_q;
  assign wbq.wbq_overflow   = ovf_q;
  assign wbq.prf_wr_enable0 = en0;
  assign wbq.prf_wr_enable1 = en1;
  assign wbq.prf_pr_idx0    = en0 ? idx_mem_q[head_q]  : '0;
  assign wbq.prf_pr_value0  = en0 ? val_mem_q[head_q]  : '0;
  assign wbq.prf_pr_idx1    = en1 ? idx_mem_q[head_p1] : '0;
  assign wbq.prf_pr_value1  = en1 ? val_mem_q[head_p1] : '0;
endmodule

// File: tb/tb_prf_wb_queue.sv
// Self-checking bench for prf_wb_queue: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_prf_wb_queue;
  localparam int DEPTH  = 8;
  localparam int IDX_W  = 7;
  localparam int DATA_W = 64;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  prf_wb_queue_if #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W)) bus ();

  prf_wb_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
    .clock (clock),
    .reset (reset),
    .wbq   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [IDX_W-1:0]  mq_idx [$];
  logic [DATA_W-1:0] mq_val [$];
  logic              ovf_m;

  logic              d  [3];
  logic [IDX_W-1:0]  ix [3];
  logic [DATA_W-1:0] vx [3];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int u = 0; u < 3; u++) begin
      d[u] = 1'b0; ix[u] = '0; vx[u] = '0;
    end
  endtask

  task automatic set_unit(input int u, input logic [IDX_W-1:0] i, input logic [DATA_W-1:0] v);
    d[u] = 1'b1; ix[u] = i; vx[u] = v;
  endtask

  // Reference: a FIFO of results; the edge pops min(2,n) and appends accepted dones.
  task automatic model_edge(input logic rst);
    int n;
    bit rdy;
    if (rst) begin
      mq_idx.delete(); mq_val.delete(); ovf_m = 1'b0;
    end else begin
      n   = mq_idx.size();
      rdy = (n <= DEPTH - 3);
      for (int k = 0; k < ((n >= 2) ? 2 : n); k++) begin
        void'(mq_idx.pop_front()); void'(mq_val.pop_front());
      end
      for (int u = 0; u < 3; u++) begin
        if (d[u]) begin
          if (rdy) begin
            mq_idx.push_back(ix[u]); mq_val.push_back(vx[u]);
          end else ovf_m = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    int n;
    n = mq_idx.size();
    check("count",   64'(bus.wbq_count), 64'(n));
    check("ready",   64'(bus.wbq_ready), 64'(n <= DEPTH - 3));
    check("ovf",     64'(bus.wbq_overflow), 64'(ovf_m));
    check("en0",     64'(bus.prf_wr_enable0), 64'(n >= 1));
    check("en1",     64'(bus.prf_wr_enable1), 64'(n >= 2));
    check("idx0",    64'(bus.prf_pr_idx0),   (n >= 1) ? 64'(mq_idx[0]) : 64'd0);
    check("val0",    bus.prf_pr_value0,      (n >= 1) ? mq_val[0] : 64'd0);
    check("idx1",    64'(bus.prf_pr_idx1),   (n >= 2) ? 64'(mq_idx[1]) : 64'd0);
    check("val1",    bus.prf_pr_value1,      (n >= 2) ? mq_val[1] : 64'd0);
  endtask

  task automatic apply(input logic rst);
    reset                = rst;
    bus.alu_sim_done     = d[0]; bus.alu_sim_pr_idx = ix[0]; bus.alu_sim_pr_value = vx[0];
    bus.alu_mul_done     = d[1]; bus.alu_mul_pr_idx = ix[1]; bus.alu_mul_pr_value = vx[1];
    bus.alu_mem_done     = d[2]; bus.alu_mem_pr_idx = ix[2]; bus.alu_mem_pr_value = vx[2];
    @(posedge clock);
    #1;
    model_edge(rst);
    check_all();
  endtask

  task automatic triple(input int base);
    clr();
    for (int u = 0; u < 3; u++)
      set_unit(u, IDX_W'(base + u), DATA_W'(64'h1000 + base + u));
  endtask

  initial begin
    ovf_m = 1'b0;
    clr();
    apply(1'b1);
    apply(1'b1);
    check("rst_count", 64'(bus.wbq_count), 64'd0);
    check("rst_ready", 64'(bus.wbq_ready), 64'd1);
    check("rst_en0",   64'(bus.prf_wr_enable0), 64'd0);
    apply(1'b0);

    // Single sim result, then drained.
    clr(); set_unit(0, 7'd5, 64'hAA);
    apply(1'b0);
    check("t1_idx0", 64'(bus.prf_pr_idx0), 64'd5);
    check("t1_val0", bus.prf_pr_value0, 64'hAA);
    check("t1_en1",  64'(bus.prf_wr_enable1), 64'd0);
    clr();
    apply(1'b0);
    check("t1_empty", 64'(bus.wbq_count), 64'd0);

    // Three at once drain as 1,2 then 3.
    clr(); set_unit(0, 7'd1, 64'h11); set_unit(1, 7'd2, 64'h22); set_unit(2, 7'd3, 64'h33);
    apply(1'b0);
    check("t2_idx0", 64'(bus.prf_pr_idx0), 64'd1);
    check("t2_idx1", 64'(bus.prf_pr_idx1), 64'd2);
    clr();
    apply(1'b0);
    check("t2_idx0b", 64'(bus.prf_pr_idx0), 64'd3);
    check("t2_en1b",  64'(bus.prf_wr_enable1), 64'd0);
    apply(1'b0);

    // Burst of 12 across pointer wrap; count 3,4,5,6.
    for (int c = 0; c < 4; c++) begin
      triple(1 + 3 * c);
      apply(1'b0);
      check("t3_count", 64'(bus.wbq_count), 64'(3 + c));
    end
    check("t3_notready", 64'(bus.wbq_ready), 64'd0);
    // Done while not ready is dropped and overflow becomes sticky.
    clr(); set_unit(1, 7'd99, 64'hDEAD);
    apply(1'b0);
    check("t4_ovf", 64'(bus.wbq_overflow), 64'd1);
    clr();
    for (int c = 0; c < 4; c++) apply(1'b0);
    check("t4_ovf_hold", 64'(bus.wbq_overflow), 64'd1);
    apply(1'b1);
    check("t4_ovf_clr", 64'(bus.wbq_overflow), 64'd0);
    apply(1'b0);

    // Reset with a done in the same cycle discards everything.
    for (int c = 0; c < 3; c++) begin
      triple(40 + 3 * c);
      apply(1'b0);
    end
    check("t5_count5", 64'(bus.wbq_count), 64'd5);
    clr(); set_unit(0, 7'd77, 64'h77);
    apply(1'b1);
    check("t5_count0", 64'(bus.wbq_count), 64'd0);
    check("t5_en0",    64'(bus.prf_wr_enable0), 64'd0);
    clr();
    apply(1'b0);
    check("t5_noentry", 64'(bus.prf_wr_enable0), 64'd0);

    // Randomized traffic at several arrival densities.
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 150; c++) begin
        int pct;
        pct = 30 + 25 * ph;
        clr();
        for (int u = 0; u < 3; u++)
          if ($urandom_range(99) < pct)
            set_unit(u, IDX_W'($urandom_range(127)), {$urandom, $urandom});
        apply($urandom_range(99) < 2);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
